// File: rtl/maze_io_frontend.sv
// Board-side I/O for the maze bomb: four button debouncers producing press pulses,
// and a WS2812-style serial driver painting the 8x8 player/goal matrix.

module maze_io_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic pulse_o
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d, prev_q, pulse_q;

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync_q[1];
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], ~btn_n_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      pulse_q  <= stable_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

module maze_io_frontend #(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int BIT_CYCLES   = 63,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int RESET_CYCLES = 2600,
  parameter int FAIL_HOLD    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_u_n,
  input  logic       btn_d_n,
  input  logic       btn_l_n,
  input  logic       btn_r_n,
  output logic       u_p,
  output logic       d_p,
  output logic       l_p,
  output logic       r_p,
  input  logic [2:0] current_state,
  input  logic [2:0] cur_x,
  input  logic [2:0] cur_y,
  input  logic [2:0] final_x,
  input  logic [2:0] final_y,
  input  logic       win,
  input  logic       fail,
  output logic       dout
);
  localparam int NUM_BTN = 4;
  localparam int FW      = $clog2(FAIL_HOLD + 1);
  localparam int CYC_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CYW     = $clog2(CYC_MAX);
  localparam logic [CYW-1:0] GAP_LAST = CYW'(RESET_CYCLES - 1);
  localparam logic [CYW-1:0] BIT_LAST = CYW'(BIT_CYCLES - 1);
  localparam logic [23:0] C_OFF = 24'h000000;
  localparam logic [23:0] C_GRN = 24'h100000;
  localparam logic [23:0] C_RED = 24'h001000;

  // ---------------- buttons ----------------
  logic [NUM_BTN-1:0] btn_n, pls;
  assign btn_n = {btn_r_n, btn_l_n, btn_d_n, btn_u_n};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    maze_io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (btn_n[i]),
      .pulse_o (pls[i])
    );
  end

  assign {r_p, l_p, d_p, u_p} = pls;

  // ---------------- fail hold ----------------
  logic [FW-1:0] fhold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 fhold_q <= '0;
    else if (fail)            fhold_q <= FW'(FAIL_HOLD);
    else if (fhold_q != '0)   fhold_q <= fhold_q - 1'b1;
  end

  // ---------------- LED driver ----------------
  typedef enum logic {S_GAP, S_BIT} drv_state_e;

  typedef struct packed {
    logic       on;
    logic       win;
    logic       red;
    logic [5:0] cur;
    logic [5:0] fin;
  } snap_t;

  drv_state_e     state_q, state_d;
  logic [CYW-1:0] cyc_q, cyc_d;
  logic [4:0]     bit_q, bit_d;
  logic [5:0]     led_q, led_d;
  snap_t          snap_q, snap_d, snap_live;
  logic           load;
  logic [23:0]    col_d;
  logic           bitv_d;
  logic [CYW-1:0] high_d;
  logic           dout_q, dout_d;

  // LED index y*8+x is exactly {y, x}, so positions compare directly against it.
  function automatic logic [23:0] cell_colour(input snap_t s, input logic [5:0] idx);
    logic [23:0] c;
    c = C_OFF;
    if (!s.on)             c = C_OFF;
    else if (s.win)        c = C_GRN;
    else if (s.red)        c = C_RED;
    else if (idx == s.cur) c = C_GRN;
    else if (idx == s.fin) c = C_RED;
    return c;
  endfunction

  always_comb begin
    snap_live.on  = (current_state == 3'd2);
    snap_live.win = win;
    snap_live.red = (fhold_q != '0);
    snap_live.cur = {cur_y, cur_x};
    snap_live.fin = {final_y, final_x};
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 1'b1;
    bit_d   = bit_q;
    led_d   = led_q;
    load    = 1'b0;
    case (state_q)
      S_GAP: begin
        if (cyc_q == GAP_LAST) begin
          state_d = S_BIT;
          cyc_d   = '0;
          bit_d   = '0;
          led_d   = '0;
          load    = 1'b1;
        end
      end
      S_BIT: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (led_q == 6'd63) begin
              state_d = S_GAP;
              led_d   = '0;
            end else begin
              led_d = led_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_GAP;
    endcase
  end

  // dout is registered from the next-state view so the line is glitch-free and
  // the first high edge after the gap lands exactly RESET_CYCLES after release.
  always_comb begin
    snap_d = load ? snap_live : snap_q;
    col_d  = cell_colour(snap_d, led_d);
    bitv_d = col_d[5'd23 - bit_d];
    high_d = bitv_d ? CYW'(T1H_CYCLES) : CYW'(T0H_CYCLES);
    dout_d = (state_d == S_BIT) && (cyc_d < high_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_GAP;
      cyc_q   <= '0;
      bit_q   <= '0;
      led_q   <= '0;
      snap_q  <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      snap_q  <= snap_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;
endmodule

// File: tb/tb_maze_io_frontend.sv
// Directed bench for maze_io_frontend: debounce pulse timing and decoded LED frames
// checked against scoreboard queues filled when stimulus is applied.

module tb_maze_io_frontend;
  localparam int DEB   = 4;
  localparam int BITC  = 10;
  localparam int T0H   = 3;
  localparam int T1H   = 7;
  localparam int RSTC  = 20;
  localparam int FHOLD = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_u_n = 1'b1, btn_d_n = 1'b1, btn_l_n = 1'b1, btn_r_n = 1'b1;
  logic       u_p, d_p, l_p, r_p;
  logic [2:0] current_state = 3'd0;
  logic [2:0] cur_x = 3'd0, cur_y = 3'd0, final_x = 3'd0, final_y = 3'd0;
  logic       win = 1'b0, fail = 1'b0;
  logic       dout;
  wire  [3:0] pls = {r_p, l_p, d_p, u_p};

  maze_io_frontend #(
    .DEB_CYCLES(DEB), .BIT_CYCLES(BITC), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .RESET_CYCLES(RSTC), .FAIL_HOLD(FHOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_u_n(btn_u_n), .btn_d_n(btn_d_n), .btn_l_n(btn_l_n), .btn_r_n(btn_r_n),
    .u_p(u_p), .d_p(d_p), .l_p(l_p), .r_p(r_p),
    .current_state(current_state), .cur_x(cur_x), .cur_y(cur_y),
    .final_x(final_x), .final_y(final_y), .win(win), .fail(fail), .dout(dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int b; int c;} pev_t;
  pev_t        pq[$];
  logic [23:0] lq[$];
  int          frames_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_col(input int led, input bit fh);
    int x, y;
    x = led % 8;
    y = led / 8;
    if (current_state != 3'd2) return 24'h000000;
    if (win)                   return 24'h100000;
    if (fh)                    return 24'h001000;
    if (x == int'(cur_x) && y == int'(cur_y))     return 24'h100000;
    if (x == int'(final_x) && y == int'(final_y)) return 24'h001000;
    return 24'h000000;
  endfunction

  task automatic push_frame(input int n, input bit fh);
    for (int i = 0; i < n; i++) lq.push_back(exp_col(i, fh));
  endtask

  task automatic wait_frame();
    int f0;
    int n;
    f0 = frames_done;
    n  = 0;
    while (frames_done == f0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("frame completes in budget", 32'(frames_done != f0), 32'd1);
    chk("frame scoreboard drained", 32'(lq.size()), 32'd0);
  endtask

  task automatic count_low(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (dout !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(RSTC));
  endtask

  // pulse scoreboard
  initial begin : pulse_mon
    pev_t e;
    forever begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        if (pls[b] !== 1'b0) begin
          if (pq.size() == 0) begin
            chk($sformatf("unexpected pulse btn%0d at cyc %0d", b, cyc), 32'(pls[b]), 32'd0);
          end else begin
            e = pq.pop_front();
            chk($sformatf("pulse button (exp btn%0d)", e.b), 32'(b), 32'(e.b));
            chk($sformatf("pulse cycle btn%0d", e.b), 32'(cyc), 32'(e.c));
          end
        end
      end
    end
  end

  // serial decoder
  logic        m_prev = 1'b0;
  int          m_hi = 0, m_lo = 0, m_last_hi = 0, m_nb = 0, m_led = 0;
  logic [23:0] m_w = '0;

  initial begin : frame_mon
    forever begin
      @(negedge clk);
      if (dout === 1'b1) begin
        if (!m_prev) begin
          if (m_lo >= RSTC) begin
            if (frames_done > 0 && lq.size() == 64)
              chk("latch gap low clocks", 32'(m_lo), 32'(BITC - T0H + RSTC));
            m_led = 0;
            m_nb  = 0;
          end else if (lq.size() > 0) begin
            chk("bit low time", 32'(m_lo), 32'(BITC - m_last_hi));
          end
          m_hi = 0;
        end
        m_hi++;
      end else begin
        if (m_prev) begin
          if (lq.size() > 0) chk("bit high time legal", 32'(m_hi == T1H || m_hi == T0H), 32'd1);
          m_w       = {m_w[22:0], (m_hi == T1H)};
          m_nb++;
          m_last_hi = m_hi;
          if (m_nb == 24) begin
            m_nb = 0;
            if (lq.size() > 0) chk($sformatf("led[%0d] colour", m_led), 32'(m_w), 32'(lq.pop_front()));
            m_led++;
            if (m_led == 64) begin
              m_led = 0;
              frames_done++;
            end
          end
          m_lo = 0;
        end
        m_lo++;
      end
      m_prev = (dout === 1'b1);
    end
  end

  initial begin : main
    int n;
    int c;
    #1 rst = 1'b0;
    current_state = 3'd2;
    cur_x = 3'd0; cur_y = 3'd0; final_x = 3'd7; final_y = 3'd7;
    repeat (3) @(negedge clk);
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset u_p", 32'(u_p), 32'd0);
    chk("reset d_p", 32'(d_p), 32'd0);
    chk("reset l_p", 32'(l_p), 32'd0);
    chk("reset r_p", 32'(r_p), 32'd0);

    // first frame after release: player (0,0) green, goal (7,7) red
    @(posedge clk);
    #2 rst = 1'b1;
    push_frame(64, 1'b0);
    count_low("low clocks after reset release");

    // glitch shorter than the settle window
    btn_u_n = 1'b0;
    repeat (2) @(negedge clk);
    btn_u_n = 1'b1;
    repeat (15) @(negedge clk);

    // clean press held long, then release
    btn_u_n = 1'b0;
    pq.push_back('{0, cyc + DEB + 3});
    repeat (20) @(negedge clk);
    btn_u_n = 1'b1;
    repeat (15) @(negedge clk);

    // two buttons together
    btn_l_n = 1'b0;
    btn_r_n = 1'b0;
    pq.push_back('{2, cyc + DEB + 3});
    pq.push_back('{3, cyc + DEB + 3});
    repeat (10) @(negedge clk);
    btn_l_n = 1'b1;
    btn_r_n = 1'b1;
    repeat (15) @(negedge clk);

    // bounce inside the settle window restarts the count
    btn_d_n = 1'b0;
    repeat (2) @(negedge clk);
    btn_d_n = 1'b1;
    @(negedge clk);
    btn_d_n = 1'b0;
    c = cyc;
    pq.push_back('{1, c + DEB + 3});
    repeat (20) @(negedge clk);
    btn_d_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("pulse scoreboard drained", 32'(pq.size()), 32'd0);

    // fail pulse: next frame all red, with player and goal on the same cell
    wait_frame();
    cur_x = 3'd2; cur_y = 3'd5; final_x = 3'd2; final_y = 3'd5;
    fail = 1'b1;
    @(negedge clk);
    fail = 1'b0;
    push_frame(64, 1'b1);

    // hold expired: positional colours return
    wait_frame();
    push_frame(64, 1'b0);

    wait_frame();
    win = 1'b1;
    push_frame(64, 1'b0);

    // idle slot overrides win; only the first 16 LEDs are checked
    wait_frame();
    current_state = 3'd0;
    cur_x = 3'd0; cur_y = 3'd0;
    push_frame(16, 1'b0);
    n = 0;
    while (lq.size() > 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("partial frame drained", 32'(lq.size()), 32'd0);

    // async reset while the line is high
    n = 0;
    while (dout !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dout high before mid-frame reset", 32'(dout), 32'd1);
    #1 rst = 1'b0;
    #1 chk("dout cleared by async reset", 32'(dout), 32'd0);
    current_state = 3'd2;
    win = 1'b0;
    cur_x = 3'd0; cur_y = 3'd0; final_x = 3'd7; final_y = 3'd7;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    push_frame(2, 1'b0);
    count_low("low clocks after mid-frame reset");
    n = 0;
    while (lq.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("restart frame drained", 32'(lq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
